hit_sfx_gen: RTL and testbench

- Upstream sound-effect source for the audio mixer. Produces the signed 16-bit sfx_waveform that the mixer adds over the music.
- A rising edge on hit starts a short square-wave "blip". The pitch sweeps downward and the amplitude decays linearly to zero.
- While idle the output is exactly 0, because the mixer uses sfx_waveform == 0 to select music-only output.

---
 rtl/hit_sfx_gen.sv | 98 +++++++++
 tb/tb_hit_sfx_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hit_sfx_gen.sv
// hit_sfx_gen: decaying, downward-sweeping square-wave blip started by a rising edge on hit
//   clk          100 MHz system clock
//   rst          asynchronous active-low reset
//   hit          trigger request; only rising edges start (or restart) an effect
//   sfx_waveform registered signed sample, exactly 0 while idle
//   busy         registered, high while an effect is playing
//   SFX_NOISE_EN when defined, phase comes from a 16-bit Galois LFSR for a noisy thud
module hit_sfx_gen #(
  parameter int DIV_START   = 50000,
  parameter int DIV_STEP    = 250,
  parameter int DIV_END     = 100000,
  parameter int STEP_CYCLES = 100000,
  parameter int AMP_MAX     = 8000,
  parameter int AMP_STEP    = 80
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hit,
  output logic signed [15:0] sfx_waveform,
  output logic               busy
);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state, state_n;
  logic hit_d, trig, phase, phase_n, flip, busy_n, tone_end, tick;
  logic [15:0] amp, amp_n, amp_dec;
  logic [21:0] half_div, half_div_n, cur_div, cur_div_n, tone_cnt, tone_n, step_cnt, step_n, div_inc;
  logic [22:0] div_sum;
  logic signed [15:0] wave_n;
  assign trig     = hit & ~hit_d;
  // cur_div holds the length of the half-period in progress, so a sweep step never truncates it
  assign tone_end = tone_cnt == cur_div - 22'd1;
  assign tick     = step_cnt == 22'(STEP_CYCLES - 1);
  assign amp_dec  = amp > 16'(AMP_STEP) ? amp - 16'(AMP_STEP) : 16'd0;
  assign div_sum  = {1'b0, half_div} + 23'(DIV_STEP);
  assign div_inc  = div_sum > 23'(DIV_END) ? 22'(DIV_END) : div_sum[21:0];
`ifdef SFX_NOISE_EN
  logic [15:0] lfsr, lfsr_adv;
  assign lfsr_adv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign flip     = lfsr_adv[0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr <= 16'hACE1;
    else lfsr <= trig ? 16'hACE1 : (state == PLAY && tone_end) ? lfsr_adv : lfsr;
`else
  assign flip = ~phase;
`endif
  always_comb begin
    state_n    = state;
    amp_n      = amp;
    half_div_n = half_div;
    cur_div_n  = cur_div;
    tone_n     = tone_cnt;
    step_n     = step_cnt;
    phase_n    = phase;
    if (trig) begin
      state_n    = PLAY;
      amp_n      = 16'(AMP_MAX);
      half_div_n = 22'(DIV_START);
      cur_div_n  = 22'(DIV_START);
      tone_n     = '0;
      step_n     = '0;
      phase_n    = 1'b1;
    end else if (state == PLAY) begin
      tone_n     = tone_end ? '0 : tone_cnt + 22'd1;
      phase_n    = tone_end ? flip : phase;
      step_n     = tick ? '0 : step_cnt + 22'd1;
      amp_n      = tick ? amp_dec : amp;
      half_div_n = tick ? div_inc : half_div;
      cur_div_n  = tone_end ? half_div_n : cur_div;
      state_n    = amp_n == 16'd0 ? IDLE : PLAY;
    end
    busy_n = state_n == PLAY;
    wave_n = busy_n ? (phase_n ? amp_n : -amp_n) : 16'sd0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      hit_d        <= 1'b0;
      amp          <= '0;
      half_div     <= '0;
      cur_div      <= '0;
      tone_cnt     <= '0;
      step_cnt     <= '0;
      phase        <= 1'b0;
      sfx_waveform <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      hit_d        <= hit;
      amp          <= amp_n;
      half_div     <= half_div_n;
      cur_div      <= cur_div_n;
      tone_cnt     <= tone_n;
      step_cnt     <= step_n;
      phase        <= phase_n;
      sfx_waveform <= wave_n;
      busy         <= busy_n;
    end
endmodule

// File: tb/tb_hit_sfx_gen.sv
// tb_hit_sfx_gen: randomized self-checking bench for hit_sfx_gen against a time-based model
module tb_hit_sfx_gen;
  localparam int DS = 6, DSTEP = 2, DEND = 11, STEP = 10, AMP = 500, ASTEP = 60;
  logic clk = 1'b0, rst = 1'b1, hit = 1'b0;
  logic signed [15:0] sfx_waveform;
  logic busy;
  int n_checks = 0, n_fail = 0;
  bit m_hit_d, m_on, m_sign, m_busy;
  int m_t, m_next;
  logic [15:0] m_lfsr;
  logic signed [15:0] m_wave;

  hit_sfx_gen #(.DIV_START(DS), .DIV_STEP(DSTEP), .DIV_END(DEND), .STEP_CYCLES(STEP),
                .AMP_MAX(AMP), .AMP_STEP(ASTEP))
    dut (.clk(clk), .rst(rst), .hit(hit), .sfx_waveform(sfx_waveform), .busy(busy));

  always #5 clk = ~clk;

  // half-period in force after k envelope ticks
  function automatic int div_at(int k);
    return (DS + k * DSTEP > DEND) ? DEND : DS + k * DSTEP;
  endfunction

  task automatic model_reset();
    m_hit_d = 0; m_on = 0; m_sign = 0; m_t = 0; m_next = 0;
    m_lfsr = 16'hACE1; m_wave = 0; m_busy = 0;
  endtask

  // one clock: update the model at the rising edge, return on the falling edge
  task automatic cyc();
    int a = 0;
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      if (hit && !m_hit_d) begin
        m_on = 1; m_t = 0; m_sign = 1; m_next = DS; m_lfsr = 16'hACE1; a = AMP;
      end else if (m_on) begin
        m_t++;
        a = AMP - (m_t / STEP) * ASTEP;
        if (a <= 0) m_on = 0;
        else if (m_t == m_next) begin
`ifdef SFX_NOISE_EN
          m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
          m_sign = m_lfsr[0];
`else
          m_sign = !m_sign;
`endif
          m_next += div_at(m_t / STEP);
        end
      end
      m_hit_d = hit;
      m_wave = m_on ? 16'(m_sign ? a : -a) : 16'sd0;
      m_busy = m_on;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      hit = ~hit;
      cyc();
      n_checks++;
      if (sfx_waveform !== 16'sd0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: wave=%0d busy=%b, required wave=0 busy=0", sfx_waveform, busy);
      end
    end
    hit = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++;
      if (sfx_waveform !== 16'sd0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release: wave=%0d busy=%b, required wave=0 busy=0", sfx_waveform, busy);
      end
    end
  endtask

  task automatic test_single();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    n_checks++;
    if (sfx_waveform !== 16'(AMP) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_first: wave=%0d busy=%b, required wave=%0d busy=1", sfx_waveform, busy, AMP);
    end
    for (int i = 0; i < 120; i++) begin
      cyc();
      n_checks++;
      if (sfx_waveform !== m_wave || busy !== m_busy) begin
        n_fail++;
        $display("FAIL single_play t=%0d: wave=%0d busy=%b, required wave=%0d busy=%b", i + 1, sfx_waveform, busy, m_wave, m_busy);
      end
    end
    n_checks++;
    if (sfx_waveform !== 16'sd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_decayed: wave=%0d busy=%b, required wave=0 busy=0", sfx_waveform, busy);
    end
  endtask

  task automatic test_retrigger_held();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    repeat ($urandom_range(20, 60)) begin
      cyc();
      n_checks++;
      if (sfx_waveform !== m_wave || busy !== m_busy) begin
        n_fail++;
        $display("FAIL retrig_pre: wave=%0d busy=%b, required wave=%0d busy=%b", sfx_waveform, busy, m_wave, m_busy);
      end
    end
    hit = 1'b1;
    cyc();
    n_checks++;
    if (sfx_waveform !== 16'(AMP) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL retrig_reload: wave=%0d busy=%b, required wave=%0d busy=1", sfx_waveform, busy, AMP);
    end
    for (int i = 0; i < 150; i++) begin
      cyc();
      n_checks++;
      if (sfx_waveform !== m_wave || busy !== m_busy) begin
        n_fail++;
        $display("FAIL held_level: wave=%0d busy=%b, required wave=%0d busy=%b", sfx_waveform, busy, m_wave, m_busy);
      end
    end
    hit = 1'b0;
    cyc();
  endtask

  task automatic test_final_tick_retrigger();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    for (int i = 0; i < 9 * STEP - 1; i++) begin
      cyc();
      n_checks++;
      if (sfx_waveform !== m_wave || busy !== m_busy) begin
        n_fail++;
        $display("FAIL final_pre: wave=%0d busy=%b, required wave=%0d busy=%b", sfx_waveform, busy, m_wave, m_busy);
      end
    end
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    n_checks++;
    if (sfx_waveform !== 16'(AMP) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL final_tick_retrig: wave=%0d busy=%b, required wave=%0d busy=1", sfx_waveform, busy, AMP);
    end
    for (int i = 0; i < 100; i++) begin
      cyc();
      n_checks++;
      if (sfx_waveform !== m_wave || busy !== m_busy) begin
        n_fail++;
        $display("FAIL final_post: wave=%0d busy=%b, required wave=%0d busy=%b", sfx_waveform, busy, m_wave, m_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) hit = ~hit;
      cyc();
      n_checks++;
      if (sfx_waveform !== m_wave || busy !== m_busy) begin
        n_fail++;
        $display("FAIL random i=%0d: wave=%0d busy=%b, required wave=%0d busy=%b", i, sfx_waveform, busy, m_wave, m_busy);
      end
    end
    hit = 1'b0;
    repeat (120) cyc();
  endtask

  task automatic test_async_reset();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    repeat (30) cyc();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: busy=%b, required busy=1", busy);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (sfx_waveform !== 16'sd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_immediate: wave=%0d busy=%b, required wave=0 busy=0", sfx_waveform, busy);
    end
    repeat (3) cyc();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      n_checks++;
      if (sfx_waveform !== 16'sd0 || busy !== 1'b0 || m_busy) begin
        n_fail++;
        $display("FAIL async_after: wave=%0d busy=%b, required wave=0 busy=0", sfx_waveform, busy);
      end
    end
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    n_checks++;
    if (sfx_waveform !== 16'(AMP) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_new_hit: wave=%0d busy=%b, required wave=%0d busy=1", sfx_waveform, busy, AMP);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_retrigger_held();
    test_final_tick_retrigger();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
